period_ctrl: RTL and testbench
==============================

Name: period_ctrl

Overview:
Up/down period selector between the button debouncers and the variable clock divider. It takes two debounced buttons and holds a saturating period register that drives the divider's period input directly. A single press steps the period once. Holding a button auto-repeats after a hold delay. Pressing both buttons restores the initial period.

Parameters:
WIDTH, 32, width of the period register and output.
PERIOD_MIN, 1, lowest legal period; must be >= 1 so the divider never sees 0.
PERIOD_MAX, 32'hFFFF_FFFF, highest legal period; must be >= PERIOD_MIN.
PERIOD_INIT, 1000, value after reset and after a both-buttons press; must lie in [PERIOD_MIN, PERIOD_MAX].
STEP, 1, increment or decrement per step; must be >= 1.
HOLD_CYCLES, 50_000_000, clk cycles from the first step to the first auto-repeat step; must be >= 1.
REPEAT_CYCLES, 10_000_000, clk cycles between auto-repeat steps; must be >= 1.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  synchronous reset, active-high.
btn_up  input  1  debounced "increase period" button, synchronous to clk.
btn_dn  input  1  debounced "decrease period" button, synchronous to clk.
period  output  WIDTH  current period, registered; feeds the divider.
changed  output  1  one-cycle pulse in the cycle after period takes a new value.
at_min  output  1  high when period == PERIOD_MIN; decoded from the period register.
at_max  output  1  high when period == PERIOD_MAX; decoded from the period register.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - period = PERIOD_INIT, changed = 0, state = IDLE.
  - Repeat counter = 0.
  - Button history registers up_q and dn_q = 1, so a button held through reset is not treated as a new press.
- Edge detect: rise_up = btn_up & ~up_q; rise_dn = btn_dn & ~dn_q. up_q and dn_q update every cycle.
- Step arithmetic: computed in WIDTH+1 bits, no wrap-around.
  - Step up: period <= (period > PERIOD_MAX-STEP) ? PERIOD_MAX : period+STEP.
  - Step down: period <= (period < PERIOD_MIN+STEP) ? PERIOD_MIN : period-STEP.
- changed: asserted for exactly one cycle, only if the new period differs from the old one. A step attempted at saturation gives changed = 0.
- State IDLE:
  - btn_up & btn_dn both high: period <= PERIOD_INIT, go to BOTH.
  - Else rise_up: step up, dir = UP, counter = 0, go to HOLD.
  - Else rise_dn: step down, dir = DN, counter = 0, go to HOLD.
- State HOLD:
  - Active button low: go to IDLE.
  - Else other button high: period <= PERIOD_INIT, go to BOTH.
  - Else counter increments; when counter == HOLD_CYCLES-1, step in dir, counter = 0, go to REPEAT.
- State REPEAT:
  - Release and both-button rules are the same as in HOLD.
  - Counter == REPEAT_CYCLES-1: step in dir, counter = 0.
- State BOTH: no stepping; go to IDLE only when both buttons are low. A button still held on return to IDLE has up_q/dn_q = 1 and does not step.
- Latency:
  - A button sampled high with its history register low at clock edge k makes period valid after edge k.
  - changed is high for the cycle following edge k.
- Simultaneous rises of both buttons in IDLE count as a both-buttons press (INIT), not as a step.
- rst has priority over every other input at every state, including mid-repeat.
- The counter is sized for max(HOLD_CYCLES, REPEAT_CYCLES).

Test Plan:
Bench parameters: WIDTH=8, PERIOD_MIN=2, PERIOD_MAX=20, PERIOD_INIT=10, STEP=3, HOLD_CYCLES=8, REPEAT_CYCLES=4.
1. Assert rst for 2 cycles, then release -> period=10, changed=0, at_min=0, at_max=0.
2. btn_up high for 1 cycle -> period=13 after that edge; changed high for exactly 1 cycle; no further change over 50 cycles.
3. btn_up held for 30 cycles -> 13 at the edge, 16 at +8 cycles, 19 at +12, 20 at +16 (at_max=1). No change and changed=0 at +20, +24 and +28.
4. From period=4, press btn_dn and hold -> 2 immediately (at_min=1). Later repeat steps leave 2 with changed=0. Releasing btn_dn returns the FSM to IDLE.
5. Press btn_up, then press btn_dn during HOLD -> period=10 the next cycle. Release btn_dn with btn_up still held -> no step. Release btn_up, then press it again -> 13.
6. btn_up held during REPEAT (period=16), assert rst for 1 cycle while the button stays high -> period=10, no step for 40 cycles. Release btn_up and press it again -> 13.

Source files
------------

// File: rtl/period_ctrl_if.sv
// Button and period bus between the debouncers, the period selector and
// the variable clock divider. The master side drives the buttons and
// observes the period; the slave side is the period selector itself.
interface period_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             btn_up;
  logic             btn_dn;
  logic [WIDTH-1:0] period;
  logic             changed;
  logic             at_min;
  logic             at_max;

  modport master (
    output btn_up,
    output btn_dn,
    input  period,
    input  changed,
    input  at_min,
    input  at_max
  );

  modport slave (
    input  btn_up,
    input  btn_dn,
    output period,
    output changed,
    output at_min,
    output at_max
  );
endinterface

// File: rtl/period_ctrl.sv
// Up/down period selector. Two debounced buttons step a saturating period
// register that feeds the clock divider directly. A press steps once,
// holding auto-repeats after a hold delay, and pressing both buttons
// restores the initial period.
module period_ctrl #(
  parameter int unsigned      WIDTH         = 32,
  parameter logic [WIDTH-1:0] PERIOD_MIN    = WIDTH'(1),
  parameter logic [WIDTH-1:0] PERIOD_MAX    = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] PERIOD_INIT   = WIDTH'(1000),
  parameter logic [WIDTH-1:0] STEP          = WIDTH'(1),
  parameter int unsigned      HOLD_CYCLES   = 50_000_000,
  parameter int unsigned      REPEAT_CYCLES = 10_000_000
) (
  input logic           clk,
  input logic           rst,
  period_ctrl_if.slave  bus
);

  // The counter only ever holds 0 .. max(HOLD_CYCLES, REPEAT_CYCLES)-1.
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  // One extra bit so that the saturation tests can never wrap.
  localparam logic [WIDTH:0] MAX_X  = {1'b0, PERIOD_MAX};
  localparam logic [WIDTH:0] MIN_X  = {1'b0, PERIOD_MIN};
  localparam logic [WIDTH:0] STEP_X = {1'b0, STEP};

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT,
    BOTH
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DN
  } dir_t;

  state_t           state;
  dir_t             dir;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] period_q;
  logic             changed_q;
  logic             up_q;
  logic             dn_q;

  logic             rise_up;
  logic             rise_dn;
  logic             active_btn;
  logic             other_btn;
  logic [WIDTH:0]   period_x;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_val;
  logic [WIDTH-1:0] step_val;
  logic [CNT_W-1:0] cnt_last;

  // Saturating next-step values, edge detection and the per-direction button view.
  always_comb begin
    period_x   = {1'b0, period_q};
    sum_x      = period_x + STEP_X;
    up_val     = (sum_x > MAX_X) ? PERIOD_MAX : sum_x[WIDTH-1:0];
    dn_val     = (period_x < (MIN_X + STEP_X)) ? PERIOD_MIN : (period_q - STEP);
    rise_up    = bus.btn_up & ~up_q;
    rise_dn    = bus.btn_dn & ~dn_q;
    active_btn = (dir == DIR_UP) ? bus.btn_up : bus.btn_dn;
    other_btn  = (dir == DIR_UP) ? bus.btn_dn : bus.btn_up;
    step_val   = (dir == DIR_UP) ? up_val : dn_val;
    cnt_last   = (state == HOLD) ? HOLD_LAST : REPEAT_LAST;
  end

  // Control FSM: owns the period register, the change pulse, the repeat
  // counter and the button history (which resets high so a button held
  // through reset is not seen as a fresh press).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= DIR_UP;
      cnt       <= '0;
      period_q  <= PERIOD_INIT;
      changed_q <= 1'b0;
      up_q      <= 1'b1;
      dn_q      <= 1'b1;
    end else begin
      up_q      <= bus.btn_up;
      dn_q      <= bus.btn_dn;
      changed_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.btn_up && bus.btn_dn) begin
            period_q  <= PERIOD_INIT;
            changed_q <= (PERIOD_INIT != period_q);
            state     <= BOTH;
          end else if (rise_up) begin
            period_q  <= up_val;
            changed_q <= (up_val != period_q);
            dir       <= DIR_UP;
            cnt       <= '0;
            state     <= HOLD;
          end else if (rise_dn) begin
            period_q  <= dn_val;
            changed_q <= (dn_val != period_q);
            dir       <= DIR_DN;
            cnt       <= '0;
            state     <= HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!active_btn) begin
            state <= IDLE;
          end else if (other_btn) begin
            period_q  <= PERIOD_INIT;
            changed_q <= (PERIOD_INIT != period_q);
            state     <= BOTH;
          end else if (cnt == cnt_last) begin
            period_q  <= step_val;
            changed_q <= (step_val != period_q);
            cnt       <= '0;
            state     <= REPEAT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BOTH: begin
          if (!bus.btn_up && !bus.btn_dn) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.period  = period_q;
  assign bus.changed = changed_q;
  assign bus.at_min  = (period_q == PERIOD_MIN);
  assign bus.at_max  = (period_q == PERIOD_MAX);

endmodule

// File: tb/tb_period_ctrl.sv
// Directed bench for period_ctrl with a small period range so that
// saturation, hold delay and auto-repeat are reached in a few cycles.
module tb_period_ctrl;

  localparam int unsigned WIDTH         = 8;
  localparam logic [7:0]  PERIOD_MIN    = 8'd2;
  localparam logic [7:0]  PERIOD_MAX    = 8'd20;
  localparam logic [7:0]  PERIOD_INIT   = 8'd10;
  localparam logic [7:0]  STEP          = 8'd3;
  localparam int unsigned HOLD_CYCLES   = 8;
  localparam int unsigned REPEAT_CYCLES = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  period_ctrl_if #(.WIDTH(WIDTH)) bus ();

  period_ctrl #(
    .WIDTH        (WIDTH),
    .PERIOD_MIN   (PERIOD_MIN),
    .PERIOD_MAX   (PERIOD_MAX),
    .PERIOD_INIT  (PERIOD_INIT),
    .STEP         (STEP),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       up;
    logic       dn;
    logic [7:0] period;
    logic       changed;
    logic       at_min;
    logic       at_max;
  } vec_t;

  vec_t vecs[21];

  // Drive inputs, let one rising edge pass, and land 1 ns after it.
  task automatic apply_stimulus(input logic r, input logic u, input logic d);
    rst        = r;
    bus.btn_up = u;
    bus.btn_dn = d;
    @(posedge clk);
    #1;
  endtask

  // Compare all four outputs against the expected values.
  task automatic check_output(input string name, input logic [7:0] p, input logic c,
                              input logic mn, input logic mx);
    checks++;
    if (bus.period !== p || bus.changed !== c || bus.at_min !== mn || bus.at_max !== mx) begin
      errors++;
      $display("[TB] FAIL %s: got period=%0d changed=%b at_min=%b at_max=%b, want period=%0d changed=%b at_min=%b at_max=%b",
               name, bus.period, bus.changed, bus.at_min, bus.at_max, p, c, mn, mx);
    end
  endtask

  // Expected period while btn_up is held from period 10, i cycles after the press edge.
  function automatic logic [7:0] hold_up_period(input int i);
    if (i < 8)       return 8'd13;
    else if (i < 12) return 8'd16;
    else if (i < 16) return 8'd19;
    else             return 8'd20;
  endfunction

  function automatic logic hold_up_changed(input int i);
    return (i == 0) || (i == 8) || (i == 12) || (i == 16);
  endfunction

  // Safety net in case the clock stalls.
  initial begin
    #200_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // rst up dn | period changed at_min at_max
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'd13, 1'b1, 1'b0, 1'b0}; // single press up
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'd13, 1'b0, 1'b0, 1'b0}; // release
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'd13, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0}; // reset
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'd13, 1'b1, 1'b0, 1'b0}; // press up -> HOLD
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'd13, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'd10, 1'b1, 1'b0, 1'b0}; // dn during HOLD -> INIT
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0}; // dn released, up held: no step
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'd13, 1'b1, 1'b0, 1'b0}; // fresh press steps
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'd13, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 8'd10, 1'b1, 1'b0, 1'b0}; // simultaneous rise -> INIT
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 8'd7,  1'b1, 1'b0, 1'b0}; // step down
    vecs[17] = '{1'b0, 1'b0, 1'b0, 8'd7,  1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 8'd4,  1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 8'd4,  1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 8'd2,  1'b1, 1'b1, 1'b0}; // 4 -> clamp at MIN, keep holding

    // Reset state, checked while in reset and right after release.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("reset_held", 8'd10, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("reset_release", 8'd10, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].up, vecs[i].dn);
      check_output($sformatf("vec%0d", i), vecs[i].period, vecs[i].changed,
                   vecs[i].at_min, vecs[i].at_max);
    end

    // btn_dn kept held at MIN: repeat steps must not pulse changed.
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1);
      check_output($sformatf("min_hold%0d", i), 8'd2, 1'b0, 1'b1, 1'b0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("min_release", 8'd2, 1'b0, 1'b1, 1'b0);
    // Back in IDLE, an up press steps instead of acting as a both-press.
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("min_then_up", 8'd5, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("min_then_up_rel", 8'd5, 1'b0, 1'b0, 1'b0);

    // Single press then a long quiet stretch.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("single_press", 8'd13, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output($sformatf("quiet%0d", i), 8'd13, 1'b0, 1'b0, 1'b0);
    end

    // Long hold of btn_up: hold delay, auto-repeat and saturation at MAX.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("hold_start", 8'd10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0);
      check_output($sformatf("hold_up%0d", i), hold_up_period(i), hold_up_changed(i),
                   1'b0, (i >= 16));
    end
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("hold_up_release", 8'd20, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of auto-repeat with the button kept high.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0);
      check_output($sformatf("pre_rst%0d", i), hold_up_period(i), hold_up_changed(i),
                   1'b0, 1'b0);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("mid_repeat_rst", 8'd10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0);
      check_output($sformatf("post_rst%0d", i), 8'd10, 1'b0, 1'b0, 1'b0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("post_rst_release", 8'd10, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("post_rst_press", 8'd13, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("post_rst_final", 8'd13, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
